// File: rtl/inst_rom_pkg.sv
// Shared bus widths, constant words and loader state type for the instruction ROM.
package inst_rom_pkg;

  localparam int unsigned REG_BUS  = 32;
  localparam int unsigned INST_BUS = 32;

  localparam logic [INST_BUS-1:0] INST_NOP  = 32'h0000_0013;
  localparam logic [REG_BUS-1:0]  ZERO_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } ld_state_e;

endpackage

// File: rtl/inst_rom_ld_packer.sv
// Packs an incoming byte stream little-endian into 32-bit words and flags
// complete words and zero-padded partial words on flush.
module inst_rom_ld_packer
  import inst_rom_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clear_i,
  input  logic                accept_i,
  input  logic [7:0]          byte_i,
  input  logic                flush_i,
  output logic [INST_BUS-1:0] word_o,
  output logic                word_full_o,
  output logic                partial_o
);

  logic [1:0]          cnt_q, cnt_d;
  logic [INST_BUS-1:0] lanes_q, lanes_d;

  // NOTE: every signal driven in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    word_o = lanes_q;
    if (accept_i) word_o[8*cnt_q +: 8] = byte_i;

    word_full_o = accept_i && (cnt_q == 2'd3);
    partial_o   = flush_i && !word_full_o && (accept_i || (cnt_q != 2'd0));

    cnt_d   = cnt_q;
    lanes_d = lanes_q;
    if (clear_i || word_full_o || flush_i) begin
      cnt_d   = 2'd0;
      lanes_d = ZERO_WORD;
    end else if (accept_i) begin
      cnt_d   = cnt_q + 2'd1;
      lanes_d = word_o;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= 2'd0;
      lanes_q <= ZERO_WORD;
    end else begin
      cnt_q   <= cnt_d;
      lanes_q <= lanes_d;
    end
  end

endmodule

// File: rtl/inst_rom.sv
// Instruction memory with same-cycle fetch and a byte-stream program loader
// that holds the core in reset while it fills the array.
module inst_rom
  import inst_rom_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rom_ce_i,
  input  logic [REG_BUS-1:0]    rom_addr_i,
  output logic [INST_BUS-1:0]   rom_data_o,
  input  logic                  ld_start_i,
  input  logic [7:0]            ld_byte_i,
  input  logic                  ld_valid_i,
  output logic                  ld_ready_o,
  input  logic                  ld_done_i,
  output logic                  ld_busy_o,
  output logic [DEPTH_LOG2:0]   ld_words_o,
  output logic                  ld_err_o,
  output logic                  cpu_rst_n_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  ld_state_e            state_q, state_d;
  logic [DEPTH_LOG2:0]  wptr_q, wptr_d;
  logic                 err_q, err_d;
  logic                 cpu_rst_n_q, cpu_rst_n_d;

  logic [INST_BUS-1:0]  mem [DEPTH];

  logic                 in_load, full, start, accept, flush, write_en;
  logic                 word_full, partial;
  logic [INST_BUS-1:0]  pack_word;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                 addr_unused;

  assign in_load   = (state_q == ST_LOAD);
  assign full      = wptr_q[DEPTH_LOG2];
  assign ld_ready_o = in_load && !full;
  assign ld_busy_o  = (state_q != ST_RUN);

  // A start pulse in LOAD restarts and overrides any byte or done in the same cycle.
  assign start    = ld_start_i && (state_q != ST_DRAIN);
  assign accept   = ld_valid_i && ld_ready_o && !ld_start_i;
  assign flush    = in_load && ld_done_i && !ld_start_i;
  assign write_en = word_full || (partial && !full);

  inst_rom_ld_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (start),
    .accept_i    (accept),
    .byte_i      (ld_byte_i),
    .flush_i     (flush),
    .word_o      (pack_word),
    .word_full_o (word_full),
    .partial_o   (partial)
  );

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    err_d   = err_q;

    unique case (state_q)
      ST_RUN: begin
        if (ld_start_i) begin
          state_d = ST_LOAD;
          wptr_d  = '0;
          err_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (ld_start_i) begin
          wptr_d = '0;
          err_d  = 1'b0;
        end else begin
          if (write_en) wptr_d = wptr_q + (DEPTH_LOG2+1)'(1);
          if ((ld_valid_i && full) || partial) err_d = 1'b1;
          if (flush) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase

    cpu_rst_n_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      wptr_q      <= '0;
      err_q       <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      err_q       <= err_d;
      cpu_rst_n_q <= cpu_rst_n_d;
    end
  end

  // NOTE: the array has no reset so it maps to RAM and keeps a loaded program across rst.
  always_ff @(posedge clk) begin
    if (write_en) mem[wptr_q[DEPTH_LOG2-1:0]] <= pack_word;
  end

  assign rd_idx      = rom_addr_i[DEPTH_LOG2+1:2];
  assign addr_unused = ^{rom_addr_i[REG_BUS-1:DEPTH_LOG2+2], rom_addr_i[1:0]};

  always_comb begin
    rom_data_o = ZERO_WORD;
    if (rom_ce_i) rom_data_o = ld_busy_o ? INST_NOP : mem[rd_idx];
  end

  assign ld_words_o  = wptr_q;
  assign ld_err_o    = err_q;
  assign cpu_rst_n_o = cpu_rst_n_q;

endmodule

// File: tb/tb_inst_rom.sv
// Directed bench for inst_rom: a full-size instance and a 4-word instance share
// the same stimulus; each check compares against hand-computed values.
module tb_inst_rom;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rom_ce = 1'b0;
  logic [31:0] rom_addr = 32'h0;
  logic        ld_start = 1'b0;
  logic [7:0]  ld_byte = 8'h0;
  logic        ld_valid = 1'b0;
  logic        ld_done = 1'b0;

  logic [31:0] data_b, data_s;
  logic        ready_b, ready_s, busy_b, busy_s, err_b, err_s, crst_b, crst_s;
  logic [10:0] words_b;
  logic [2:0]  words_s;

  int tests = 0;
  int fails = 0;

  inst_rom #(.DEPTH_LOG2(10)) dut (
    .clk(clk), .rst(rst), .rom_ce_i(rom_ce), .rom_addr_i(rom_addr), .rom_data_o(data_b),
    .ld_start_i(ld_start), .ld_byte_i(ld_byte), .ld_valid_i(ld_valid), .ld_ready_o(ready_b),
    .ld_done_i(ld_done), .ld_busy_o(busy_b), .ld_words_o(words_b), .ld_err_o(err_b),
    .cpu_rst_n_o(crst_b)
  );

  inst_rom #(.DEPTH_LOG2(2)) dut_s (
    .clk(clk), .rst(rst), .rom_ce_i(rom_ce), .rom_addr_i(rom_addr), .rom_data_o(data_s),
    .ld_start_i(ld_start), .ld_byte_i(ld_byte), .ld_valid_i(ld_valid), .ld_ready_o(ready_s),
    .ld_done_i(ld_done), .ld_busy_o(busy_s), .ld_words_o(words_s), .ld_err_o(err_s),
    .cpu_rst_n_o(crst_s)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    ld_byte  = b;
    ld_valid = 1'b1;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic pulse_start();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
  endtask

  task automatic pulse_done();
    ld_done = 1'b1;
    tick();
    ld_done = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] addr);
    rom_addr = addr;
    #1;
  endtask

  initial begin
    // Reset
    #2 rst = 1'b0;
    tick();
    tick();
    check("rst_cpu_rst_n", 32'(crst_b), 32'h0);
    check("rst_busy", 32'(busy_b), 32'h0);
    check("rst_ready", 32'(ready_b), 32'h0);
    check("rst_err", 32'(err_b), 32'h0);
    check("rst_words", 32'(words_b), 32'h0);
    rst = 1'b1;
    #1;
    check("release_cpu_rst_n_low", 32'(crst_b), 32'h0);
    tick();
    check("release_cpu_rst_n_high", 32'(crst_b), 32'h1);
    fetch(32'h0);
    check("ce_off_zero", data_b, 32'h0000_0000);

    // Two-word load
    rom_ce = 1'b1;
    pulse_start();
    check("load_busy", 32'(busy_b), 32'h1);
    check("load_cpu_rst_n", 32'(crst_b), 32'h0);
    check("load_ready", 32'(ready_b), 32'h1);
    check("load_nop_fetch", data_b, 32'h0000_0013);
    for (int r = 0; r < 2; r++) begin
      send_byte(8'h13); send_byte(8'h05); send_byte(8'h10); send_byte(8'h00);
    end
    check("load_words_pre_done", 32'(words_b), 32'h2);
    pulse_done();
    check("drain_busy", 32'(busy_b), 32'h1);
    check("drain_ready", 32'(ready_b), 32'h0);
    check("drain_cpu_rst_n", 32'(crst_b), 32'h0);
    check("drain_nop_fetch", data_b, 32'h0000_0013);
    tick();
    check("run_busy", 32'(busy_b), 32'h0);
    check("run_cpu_rst_n", 32'(crst_b), 32'h1);
    check("run_words", 32'(words_b), 32'h2);
    check("run_err", 32'(err_b), 32'h0);
    fetch(32'h0);
    check("mem0", data_b, 32'h0010_0513);
    fetch(32'h4);
    check("mem1", data_b, 32'h0010_0513);

    // Partial final word
    pulse_start();
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04); send_byte(8'h05);
    check("partial_words_before_done", 32'(words_b), 32'h1);
    pulse_done();
    check("partial_words", 32'(words_b), 32'h2);
    check("partial_err", 32'(err_b), 32'h1);
    tick();
    fetch(32'h0);
    check("partial_mem0", data_b, 32'h0403_0201);
    fetch(32'h4);
    check("partial_mem1", data_b, 32'h0000_0005);
    fetch(32'h0000_1004);
    check("wrap_0x1004", data_b, 32'h0000_0005);
    fetch(32'h6);
    check("low_bits_0x6", data_b, 32'h0000_0005);
    check("err_sticky_run", 32'(err_b), 32'h1);

    // Mid-load reset
    pulse_start();
    check("start_clears_err", 32'(err_b), 32'h0);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    send_byte(8'h11); send_byte(8'h22);
    check("midload_words", 32'(words_b), 32'h1);
    rst = 1'b0;
    #1;
    check("midload_rst_busy", 32'(busy_b), 32'h0);
    check("midload_rst_cpu_rst_n", 32'(crst_b), 32'h0);
    check("midload_rst_words", 32'(words_b), 32'h0);
    tick();
    rst = 1'b1;
    #1;
    check("midload_release_low", 32'(crst_b), 32'h0);
    tick();
    check("midload_release_high", 32'(crst_b), 32'h1);
    fetch(32'h0);
    check("midload_mem0_kept", data_b, 32'hDDCC_BBAA);
    fetch(32'h4);
    check("midload_mem1_kept", data_b, 32'h0000_0005);

    // Start beats simultaneous done and byte
    pulse_start();
    send_byte(8'h31); send_byte(8'h32); send_byte(8'h33); send_byte(8'h34);
    check("restart_words_pre", 32'(words_b), 32'h1);
    ld_start = 1'b1; ld_done = 1'b1; ld_valid = 1'b1; ld_byte = 8'h99;
    tick();
    ld_start = 1'b0; ld_done = 1'b0; ld_valid = 1'b0;
    check("restart_busy", 32'(busy_b), 32'h1);
    check("restart_words", 32'(words_b), 32'h0);
    check("restart_cpu_rst_n", 32'(crst_b), 32'h0);
    pulse_done();
    check("restart_drain_err", 32'(err_b), 32'h0);
    check("restart_drain_words", 32'(words_b), 32'h0);
    tick();
    fetch(32'h0);
    check("restart_mem0", data_b, 32'h3433_3231);

    // Fill the 4-word instance past capacity
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      ld_byte  = 8'(i);
      ld_valid = 1'b1;
      #1;
      check($sformatf("small_ready_%0d", i), 32'(ready_s), (i < 16) ? 32'h1 : 32'h0);
      if (i == 16) check("small_err_before_extra", 32'(err_s), 32'h0);
      tick();
    end
    ld_valid = 1'b0;
    #1;
    check("small_full_words", 32'(words_s), 32'h4);
    check("small_full_ready", 32'(ready_s), 32'h0);
    check("small_full_err", 32'(err_s), 32'h1);
    pulse_done();
    tick();
    check("small_run_busy", 32'(busy_s), 32'h0);
    check("small_run_err", 32'(err_s), 32'h1);
    check("small_run_words", 32'(words_s), 32'h4);
    fetch(32'h4);
    check("small_mem1", data_s, 32'h0706_0504);
    fetch(32'hC);
    check("small_mem3", data_s, 32'h0F0E_0D0C);
    fetch(32'h10);
    check("small_wrap_mem0", data_s, 32'h0302_0100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
